// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: sequencer state codes,
// operation codes, internal word width and the displayable result range.
package calc_pkg;

    localparam int LARG  = 9;
    localparam int MAG_W = 7;

    localparam logic [2:0] REPOUSO = 3'd0;
    localparam logic [2:0] PEDE_A  = 3'd1;
    localparam logic [2:0] PEDE_B  = 3'd2;
    localparam logic [2:0] CALCULA = 3'd3;
    localparam logic [2:0] FIM     = 3'd4;

    localparam logic OP_SOMA = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    localparam logic signed [LARG-1:0] LIM_POS = 9'sd127;
    localparam logic signed [LARG-1:0] LIM_NEG = -9'sd127;

    typedef struct packed {
        logic [MAG_W-1:0] mag;
        logic             sinal;
    } operando_t;

    // True when a result cannot be shown as sign + 7-bit magnitude.
    function automatic logic fora_de_gama(input logic signed [LARG-1:0] v);
        return (v > LIM_POS) || (v < LIM_NEG);
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Operand/result bus of the calculator sequencer plus its converter handshake;
// master is the sequencer side, slave is the surrounding logic.
interface calc_sequencer_if;
    import calc_pkg::*;

    logic                inicio;
    logic                operacao;
    logic [MAG_W-1:0]    binario_a;
    logic                sinal_a;
    logic [MAG_W-1:0]    binario_b;
    logic                sinal_b;

    logic                conv_pedido;
    logic [MAG_W-1:0]    conv_binario;
    logic                conv_sinal;
    logic [LARG-1:0]     conv_numero;
    logic                conv_pronto;

    logic [LARG-1:0]     resultado;
    logic                transbordo;
    logic                erro;
    logic                ocupado;
    logic                valido;

    modport master (
        input  inicio, operacao, binario_a, sinal_a, binario_b, sinal_b,
        input  conv_numero, conv_pronto,
        output conv_pedido, conv_binario, conv_sinal,
        output resultado, transbordo, erro, ocupado, valido
    );

    modport slave (
        output inicio, operacao, binario_a, sinal_a, binario_b, sinal_b,
        output conv_numero, conv_pronto,
        input  conv_pedido, conv_binario, conv_sinal,
        input  resultado, transbordo, erro, ocupado, valido
    );

endinterface

// File: rtl/calc_alu.sv
// Combinational 9-bit two's-complement add/subtract with display-range flag.
// No latency, no handshake; the sequencer registers the outputs.
module calc_alu
    import calc_pkg::*;
(
    input  logic [LARG-1:0] op_a,
    input  logic [LARG-1:0] op_b,
    input  logic            operacao,
    output logic [LARG-1:0] sum,
    output logic            fora_gama
);

    always_comb begin
        sum       = (operacao == OP_SUB) ? (op_a - op_b) : (op_a + op_b);
        fora_gama = fora_de_gama(signed'(sum));
    end

endmodule

// File: rtl/calc_sequencer.sv
// Captures two sign-magnitude operands, converts each through the shared
// converter, then adds/subtracts and publishes a registered result.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int LIMITE = 15
)
(
    input  logic              relogio,
    input  logic              reiniciar_n,
    calc_sequencer_if.master  bus
);

    logic [2:0]      estado;
    operando_t       cap_a;
    operando_t       cap_b;
    logic            cap_op;
    logic [LARG-1:0] op_a;
    logic [LARG-1:0] op_b;
    logic [3:0]      contador;
    logic [LARG-1:0] resultado;
    logic            transbordo;
    logic            erro;

    logic [LARG-1:0] alu_sum;
    logic            alu_fora;
    logic            expirou;

    assign expirou = (contador == 4'(LIMITE));

    calc_alu u_alu (
        .op_a      (op_a),
        .op_b      (op_b),
        .operacao  (cap_op),
        .sum       (alu_sum),
        .fora_gama (alu_fora)
    );

    always_ff @(posedge relogio or negedge reiniciar_n) begin
        if (!reiniciar_n) begin
            estado     <= REPOUSO;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_op     <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            contador   <= '0;
            resultado  <= '0;
            transbordo <= 1'b0;
            erro       <= 1'b0;
        end else begin
            case (estado)
                REPOUSO: begin
                    if (bus.inicio) begin
                        cap_a    <= '{mag: bus.binario_a, sinal: bus.sinal_a};
                        cap_b    <= '{mag: bus.binario_b, sinal: bus.sinal_b};
                        cap_op   <= bus.operacao;
                        erro     <= 1'b0;
                        contador <= '0;
                        estado   <= PEDE_A;
                    end
                end
                PEDE_A, PEDE_B: begin
                    // A ready converter wins even on the last allowed cycle.
                    if (bus.conv_pronto) begin
                        if (estado == PEDE_A) begin
                            op_a   <= bus.conv_numero;
                            estado <= PEDE_B;
                        end else begin
                            op_b   <= bus.conv_numero;
                            estado <= CALCULA;
                        end
                        contador <= '0;
                    end else if (expirou) begin
                        erro       <= 1'b1;
                        resultado  <= '0;
                        transbordo <= 1'b0;
                        contador   <= '0;
                        estado     <= FIM;
                    end else begin
                        contador <= contador + 4'd1;
                    end
                end
                CALCULA: begin
                    resultado  <= alu_sum;
                    transbordo <= alu_fora;
                    estado     <= FIM;
                end
                FIM: begin
                    estado <= REPOUSO;
                end
                default: begin
                    estado <= REPOUSO;
                end
            endcase
        end
    end

    // Request stays high across PEDE_A -> PEDE_B; only the operand changes.
    assign bus.conv_pedido  = (estado == PEDE_A) || (estado == PEDE_B);
    assign bus.conv_binario = (estado == PEDE_B) ? cap_b.mag :
                              (estado == PEDE_A) ? cap_a.mag : '0;
    assign bus.conv_sinal   = (estado == PEDE_B) ? cap_b.sinal :
                              (estado == PEDE_A) ? cap_a.sinal : 1'b0;

    assign bus.resultado  = resultado;
    assign bus.transbordo = transbordo;
    assign bus.erro       = erro;
    assign bus.ocupado    = (estado != REPOUSO);
    assign bus.valido     = (estado == FIM);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural converter of adjustable latency.
module tb_calc_sequencer;

    logic relogio;
    logic reiniciar_n;

    calc_sequencer_if bus ();

    calc_sequencer #(.LIMITE(15)) dut (
        .relogio     (relogio),
        .reiniciar_n (reiniciar_n),
        .bus         (bus)
    );

    initial relogio = 1'b0;
    always #5 relogio = ~relogio;

    int   n_cmp = 0;
    int   n_bad = 0;

    int   conv_lat;
    logic conv_mute;
    int   conv_cnt;

    // Converter answers conv_lat cycles after the current operand is first requested.
    always @(posedge relogio or negedge reiniciar_n) begin
        if (!reiniciar_n)
            conv_cnt <= 0;
        else if (bus.conv_pedido && !bus.conv_pronto)
            conv_cnt <= conv_cnt + 1;
        else
            conv_cnt <= 0;
    end

    assign bus.conv_pronto = bus.conv_pedido && !conv_mute && (conv_cnt == conv_lat);
    assign bus.conv_numero = bus.conv_sinal ? (9'd0 - {2'b00, bus.conv_binario})
                                            : {2'b00, bus.conv_binario};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int   lat_out;
    int   ped_out;
    logic got_vld;

    task automatic run_op(input logic [6:0] am, input logic as_, input logic [6:0] bm,
                          input logic bs, input logic op, input int lat, input int disturb_at);
        int n;
        conv_lat = lat;
        @(negedge relogio);
        bus.binario_a = am;  bus.sinal_a = as_;
        bus.binario_b = bm;  bus.sinal_b = bs;
        bus.operacao  = op;
        bus.inicio    = 1'b1;
        @(negedge relogio);
        bus.inicio = 1'b0;
        chk("erro_cleared_on_start", 16'(bus.erro), 16'd0);
        n = 0; ped_out = 0; got_vld = 1'b0;
        while (n < 200) begin
            if (bus.valido) begin
                got_vld = 1'b1;
                break;
            end
            if (bus.conv_pedido) ped_out++;
            if (n == disturb_at) begin
                bus.inicio    = 1'b1;
                bus.binario_a = ~am;  bus.sinal_a = ~as_;
                bus.binario_b = ~bm;  bus.sinal_b = ~bs;
                bus.operacao  = ~op;
            end else if (n == disturb_at + 1) begin
                bus.inicio = 1'b0;
            end
            @(negedge relogio);
            n++;
        end
        lat_out = n + 1;
        chk("valido_seen", 16'(got_vld), 16'd1);
        @(negedge relogio);
        chk("valido_one_cycle", 16'(bus.valido), 16'd0);
        chk("idle_after_fim", 16'(bus.ocupado), 16'd0);
    endtask

    task automatic chk_res(input string tag, input logic [8:0] res, input logic tr, input logic er);
        chk({tag, "_resultado"}, 16'(bus.resultado), 16'(res));
        chk({tag, "_transbordo"}, 16'(bus.transbordo), 16'(tr));
        chk({tag, "_erro"}, 16'(bus.erro), 16'(er));
    endtask

    initial begin
        logic vld_during_rst;
        reiniciar_n   = 1'b0;
        conv_lat      = 0;
        conv_mute     = 1'b0;
        bus.inicio    = 1'b0;
        bus.operacao  = 1'b0;
        bus.binario_a = '0;  bus.sinal_a = 1'b0;
        bus.binario_b = '0;  bus.sinal_b = 1'b0;

        #12;
        chk("rst_ocupado",   16'(bus.ocupado),     16'd0);
        chk("rst_valido",    16'(bus.valido),      16'd0);
        chk("rst_pedido",    16'(bus.conv_pedido), 16'd0);
        chk("rst_resultado", 16'(bus.resultado),   16'd0);
        chk("rst_erro",      16'(bus.erro),        16'd0);
        @(negedge relogio);
        reiniciar_n = 1'b1;

        // +5 + +3, converter immediate
        run_op(7'd5, 1'b0, 7'd3, 1'b0, 1'b0, 0, -10);
        chk("imm_latency", 16'(lat_out), 16'd4);
        chk("imm_pedido_cycles", 16'(ped_out), 16'd2);
        chk_res("p5p3", 9'h008, 1'b0, 1'b0);

        // +5 - +9, 9-cycle converter
        run_op(7'd5, 1'b0, 7'd9, 1'b0, 1'b1, 8, -10);
        chk("slow_latency", 16'(lat_out), 16'd20);
        chk("slow_pedido_cycles", 16'(ped_out), 16'd18);
        chk_res("p5m9", 9'h1FC, 1'b0, 1'b0);

        run_op(7'd100, 1'b1, 7'd100, 1'b1, 1'b0, 0, -10);
        chk_res("m100pm100", 9'h138, 1'b1, 1'b0);

        run_op(7'd127, 1'b0, 7'd127, 1'b1, 1'b1, 1, -10);
        chk_res("p127mm127", 9'h0FE, 1'b1, 1'b0);

        // display-range edges
        run_op(7'd127, 1'b0, 7'd0, 1'b0, 1'b0, 0, -10);
        chk_res("p127p0", 9'h07F, 1'b0, 1'b0);
        run_op(7'd127, 1'b1, 7'd0, 1'b0, 1'b0, 0, -10);
        chk_res("m127p0", 9'h181, 1'b0, 1'b0);
        run_op(7'd127, 1'b0, 7'd1, 1'b0, 1'b0, 0, -10);
        chk_res("p127p1", 9'h080, 1'b1, 1'b0);
        run_op(7'd127, 1'b1, 7'd1, 1'b0, 1'b1, 0, -10);
        chk_res("m127m1", 9'h180, 1'b1, 1'b0);

        // negative zero minus +7
        run_op(7'd0, 1'b1, 7'd7, 1'b0, 1'b1, 2, -10);
        chk_res("negzero", 9'h1F9, 1'b0, 1'b0);

        // converter never answers
        conv_mute = 1'b1;
        run_op(7'd9, 1'b0, 7'd9, 1'b0, 1'b0, 0, -10);
        chk_res("timeout", 9'h000, 1'b0, 1'b1);
        conv_mute = 1'b0;

        run_op(7'd20, 1'b0, 7'd30, 1'b1, 1'b0, 0, -10);
        chk_res("after_timeout", 9'h1F6, 1'b0, 1'b0);

        // new inicio and operand changes while PEDE_B is running
        run_op(7'd10, 1'b0, 7'd4, 1'b0, 1'b1, 3, 5);
        chk_res("disturbed", 9'h006, 1'b0, 1'b0);
        @(negedge relogio);
        chk("no_second_op", 16'(bus.ocupado), 16'd0);

        // leave a non-zero result, then reset in PEDE_B
        run_op(7'd127, 1'b0, 7'd127, 1'b1, 1'b1, 0, -10);
        chk_res("pre_reset", 9'h0FE, 1'b1, 1'b0);
        conv_lat = 3;
        @(negedge relogio);
        bus.binario_a = 7'd1;  bus.sinal_a = 1'b0;
        bus.binario_b = 7'd2;  bus.sinal_b = 1'b0;
        bus.operacao  = 1'b0;
        bus.inicio    = 1'b1;
        @(negedge relogio);
        bus.inicio = 1'b0;
        repeat (5) @(negedge relogio);
        chk("pede_b_pedido", 16'(bus.conv_pedido), 16'd1);
        reiniciar_n = 1'b0;
        #1;
        chk("arst_resultado",  16'(bus.resultado),   16'd0);
        chk("arst_transbordo", 16'(bus.transbordo),  16'd0);
        chk("arst_ocupado",    16'(bus.ocupado),     16'd0);
        chk("arst_pedido",     16'(bus.conv_pedido), 16'd0);
        vld_during_rst = bus.valido;
        for (int i = 0; i < 3; i++) begin
            @(negedge relogio);
            vld_during_rst = vld_during_rst | bus.valido;
        end
        chk("arst_no_valido", 16'(vld_during_rst), 16'd0);
        reiniciar_n = 1'b1;

        run_op(7'd50, 1'b0, 7'd25, 1'b1, 1'b1, 1, -10);
        chk_res("post_reset", 9'h04B, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Top-level sequencer of the simple calculator datapath. Captures two 7-bit sign-magnitude operands and an operation code. Drives the shared two's-complement converter once per operand over a request/ready handshake, then performs a 9-bit add or subtract and publishes the result with an out-of-range flag. Sits between the keypad/switch input logic and the result display.

Parameters:
LIMITE, 15, max cycles to wait for conv_pronto per operand before aborting (4-bit counter)
LARG, 9, internal two's-complement word width (fixed; not for retuning)

Ports:
relogio  in  1  system clock, rising edge
reiniciar_n  in  1  asynchronous active-low reset
inicio  in  1  start request, sampled each rising edge
operacao  in  1  0 = A+B, 1 = A-B
binario_a  in  7  operand A magnitude
sinal_a  in  1  operand A sign (1 = negative)
binario_b  in  7  operand B magnitude
sinal_b  in  1  operand B sign
conv_pedido  out  1  converter request, level
conv_binario  out  7  magnitude presented to the converter
conv_sinal  out  1  sign presented to the converter
conv_numero  in  9  converter two's-complement output
conv_pronto  in  1  converter result valid
resultado  out  9  two's-complement result, registered
transbordo  out  1  result outside -127..+127 (not displayable as sign + 7 bits)
erro  out  1  converter timeout on last operation
ocupado  out  1  high in every state except REPOUSO
valido  out  1  one-cycle pulse: resultado/transbordo/erro updated

Behaviour:
- Reset (async, reiniciar_n=0): state REPOUSO; all outputs 0; internal regs (op_a, op_b, captured operands, counter) 0. Reset mid-operation aborts immediately; no valido pulse is produced.
- States: REPOUSO, PEDE_A, PEDE_B, CALCULA, FIM.
- REPOUSO: inicio=1 -> capture binario_a/sinal_a/binario_b/sinal_b/operacao, clear erro, go PEDE_A.
- inicio while ocupado=1 is ignored; input changes after capture are ignored.
- PEDE_A: conv_pedido=1, conv_binario/conv_sinal = captured A, held stable. At the edge where conv_pronto=1: op_a <= conv_numero, counter <= 0, go PEDE_B. Otherwise counter++. When counter==LIMITE with conv_pronto=0: erro <= 1, resultado <= 0, transbordo <= 0, go FIM.
- PEDE_B: identical for operand B into op_b; success -> CALCULA.
- conv_pedido drops on the cycle after conv_pronto is sampled (one idle cycle between A and B requests is not required; the request stays high across PEDE_A->PEDE_B with new operand values). conv_pronto outside PEDE_x is ignored.
- CALCULA: resultado <= operacao ? op_a - op_b : op_a + op_b, 9-bit wrap. Operand range is -127..+127, so the true result (-254..+254) always fits in 9 bits. transbordo <= (resultado > +127 or < -127). Go FIM.
- FIM: valido=1 for exactly one cycle; go REPOUSO. resultado/transbordo/erro hold until the next FIM or reset.
- Latency with conv_pronto high on the first request cycle: inicio sampled at edge 0 -> valido high in cycle after edge 3. Each converter wait cycle adds 1.
- Negative zero (sinal=1, magnitude 0) is passed through. The converter returns 0, and the result is treated as 0.

Decomposition:
- Shared package calc_pkg: state encodings (REPOUSO..FIM), OP_SOMA=0/OP_SUB=1, LARG=9, display limits +127/-127.
- One combinational sub-module, calc_alu: inputs op_a, op_b (9 b) and operacao; outputs sum (9 b) and fora_gama. The sequencer registers its outputs in CALCULA.

Test Plan:
- A=+5, B=+3, op=0, converter ready immediately -> valido 4 cycles after inicio, resultado=9'h008, transbordo=0, erro=0.
- A=+5, B=+9, op=1, converter 9-cycle latency -> resultado=9'h1FC (-4), transbordo=0. conv_pedido high 9 cycles per operand. valido exactly one cycle.
- A=-100, B=-100, op=0 -> resultado=9'h138 (-200), transbordo=1. A=+127, B=-127, op=1 -> 9'h0FE (+254), transbordo=1.
- conv_pronto never asserted -> after LIMITE=15 wait cycles in PEDE_A: erro=1, resultado=0, valido pulse, back to REPOUSO. Next inicio clears erro.
- inicio pulsed again and operands changed during PEDE_B -> result uses originally captured values; no second operation starts.
- reiniciar_n low during PEDE_B -> all outputs 0 immediately (asynchronously), no valido. After release, a new inicio completes normally.
